// File: rtl/cam_driver.sv
// cam_driver: command-level initiator for the cam block, with an occupancy bitmap for INSERT/FLUSH.
// Optional hit/miss statistics ports are enabled by defining CAM_DRIVER_STATS_EN.
package cam_driver_pkg;
    localparam int CAM_KEY_WIDTH  = 32;
    localparam int CAM_ADDR_WIDTH = 4;

    typedef struct packed {
        logic [CAM_ADDR_WIDTH-1:0] addr;
        logic                      addr_vld;
        logic                      we;
        logic [CAM_KEY_WIDTH-1:0]  data;
        logic                      data_vld;
    } cam_req_t;

    typedef struct packed {
        logic [CAM_ADDR_WIDTH-1:0] addr;
        logic                      addr_vld;
        logic [CAM_KEY_WIDTH-1:0]  data;
        logic                      data_vld;
    } cam_resp_t;

    localparam logic [2:0] OP_READ   = 3'd0;
    localparam logic [2:0] OP_WRITE  = 3'd1;
    localparam logic [2:0] OP_DELETE = 3'd2;
    localparam logic [2:0] OP_SEARCH = 3'd3;
    localparam logic [2:0] OP_INSERT = 3'd4;
    localparam logic [2:0] OP_FLUSH  = 3'd5;
endpackage

module cam_driver
    import cam_driver_pkg::*;
#(
    parameter int KEY_WIDTH  = CAM_KEY_WIDTH,
    parameter int KEY_DEPTH  = 16,
    parameter int ADDR_WIDTH = $clog2(KEY_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [KEY_WIDTH-1:0]  cmd_key,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_hit,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic [KEY_WIDTH-1:0]  rsp_key,
    output logic                  rsp_full,
    output logic                  rsp_err,
`ifdef CAM_DRIVER_STATS_EN
    output logic [31:0]           stat_hit,
    output logic [31:0]           stat_miss,
`endif
    output cam_req_t              cam_req,
    input  cam_resp_t             cam_resp
);
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_INS_WR, S_FLUSH, S_RESP} state_t;

    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(KEY_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(KEY_DEPTH - 1);

    state_t                r_state, w_next_state;
    logic [2:0]            r_op;
    logic [ADDR_WIDTH-1:0] r_addr, r_ins_addr, r_flush_cnt, w_free_addr;
    logic [KEY_WIDTH-1:0]  r_key;
    logic [KEY_DEPTH-1:0]  r_occ;
    logic                  r_rsp_valid, r_rsp_hit, r_rsp_full, r_rsp_err;
    logic [ADDR_WIDTH-1:0] r_rsp_addr;
    logic [KEY_WIDTH-1:0]  r_rsp_key;
    logic                  w_err, w_full, w_flush_done, w_rsp_load;
    logic                  w_rsp_hit, w_rsp_full, w_rsp_err;
    logic [ADDR_WIDTH-1:0] w_rsp_addr;
    logic [KEY_WIDTH-1:0]  w_rsp_key;
    logic                  w_unused;

    function automatic logic [ADDR_WIDTH-1:0] lowest_free(input logic [KEY_DEPTH-1:0] occ);
        lowest_free = '0;
        for (int i = KEY_DEPTH - 1; i >= 0; i--) begin
            if (!occ[i]) lowest_free = ADDR_WIDTH'(i);
        end
    endfunction

    assign w_unused     = cam_resp.data_vld;
    assign w_full       = &r_occ;
    assign w_free_addr  = lowest_free(r_occ);
    assign w_err        = (r_op > OP_FLUSH) ||
                          ((r_op <= OP_DELETE) && ({1'b0, r_addr} >= DEPTH_EXT));
    assign w_flush_done = (r_state == S_FLUSH) && (r_flush_cnt == LAST_IDX);
    assign w_rsp_load   = (w_next_state == S_RESP) && (r_state != S_RESP);

    assign cmd_ready = (r_state == S_IDLE) && !rst;
    assign rsp_valid = r_rsp_valid;
    assign rsp_hit   = r_rsp_hit;
    assign rsp_addr  = r_rsp_addr;
    assign rsp_key   = r_rsp_key;
    assign rsp_full  = r_rsp_full;
    assign rsp_err   = r_rsp_err;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state decode; INSERT only detours through INS_WR on a miss with a free slot
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (cmd_valid) w_next_state = S_ISSUE; else w_next_state = S_IDLE;
            S_ISSUE: begin
                if (w_err)                      w_next_state = S_RESP;
                else if (r_op == OP_FLUSH)      w_next_state = S_FLUSH;
                else if ((r_op == OP_INSERT) && !cam_resp.addr_vld && !w_full)
                                                w_next_state = S_INS_WR;
                else                            w_next_state = S_RESP;
            end
            S_INS_WR: w_next_state = S_RESP;
            S_FLUSH:  if (w_flush_done) w_next_state = S_RESP; else w_next_state = S_FLUSH;
            S_RESP:   if (rsp_ready) w_next_state = S_IDLE; else w_next_state = S_RESP;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // CAM request decode from state and latched command only
    always_comb begin
        cam_req = '0;
        case (r_state)
            S_ISSUE: begin
                if (!w_err) begin
                    case (r_op)
                        OP_READ:   begin cam_req.addr = r_addr; cam_req.addr_vld = 1'b1; end
                        OP_WRITE:  begin
                            cam_req.addr = r_addr; cam_req.addr_vld = 1'b1; cam_req.we = 1'b1;
                            cam_req.data = r_key;  cam_req.data_vld = 1'b1;
                        end
                        OP_DELETE: begin cam_req.addr = r_addr; cam_req.addr_vld = 1'b1; cam_req.we = 1'b1; end
                        OP_SEARCH, OP_INSERT: cam_req.data = r_key;
                        default:   cam_req = '0;
                    endcase
                end else begin
                    cam_req = '0;
                end
            end
            S_INS_WR: begin
                cam_req.addr = r_ins_addr; cam_req.addr_vld = 1'b1; cam_req.we = 1'b1;
                cam_req.data = r_key;      cam_req.data_vld = 1'b1;
            end
            S_FLUSH:  begin cam_req.addr = r_flush_cnt; cam_req.addr_vld = 1'b1; cam_req.we = 1'b1; end
            default:  cam_req = '0;
        endcase
    end

    // Result fields for the cycle that enters RESP
    always_comb begin
        w_rsp_hit  = 1'b0;
        w_rsp_addr = '0;
        w_rsp_key  = '0;
        w_rsp_full = 1'b0;
        w_rsp_err  = 1'b0;
        case (r_state)
            S_ISSUE: begin
                if (w_err) begin
                    w_rsp_err = 1'b1;
                end else begin
                    case (r_op)
                        OP_READ:   begin w_rsp_hit = r_occ[r_addr]; w_rsp_addr = r_addr; w_rsp_key = cam_resp.data; end
                        OP_WRITE:  begin w_rsp_hit = r_occ[r_addr]; w_rsp_addr = r_addr; w_rsp_key = r_key; end
                        OP_DELETE: begin w_rsp_hit = r_occ[r_addr]; w_rsp_addr = r_addr; end
                        OP_SEARCH, OP_INSERT: begin
                            w_rsp_hit  = cam_resp.addr_vld;
                            w_rsp_addr = cam_resp.addr_vld ? cam_resp.addr : '0;
                            w_rsp_key  = r_key;
                            w_rsp_full = (r_op == OP_INSERT) && !cam_resp.addr_vld && w_full;
                        end
                        default:   w_rsp_err = 1'b0;
                    endcase
                end
            end
            S_INS_WR: begin w_rsp_addr = r_ins_addr; w_rsp_key = r_key; end
            S_FLUSH:  w_rsp_addr = LAST_IDX;
            default:  w_rsp_err = 1'b0;
        endcase
    end

    // Response registers, held until the handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0; r_rsp_hit <= 1'b0; r_rsp_addr <= '0;
            r_rsp_key   <= '0;   r_rsp_full <= 1'b0; r_rsp_err <= 1'b0;
        end else if (w_rsp_load) begin
            r_rsp_valid <= 1'b1;       r_rsp_hit  <= w_rsp_hit;  r_rsp_addr <= w_rsp_addr;
            r_rsp_key   <= w_rsp_key;  r_rsp_full <= w_rsp_full; r_rsp_err  <= w_rsp_err;
        end else if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    // Command capture, occupancy bitmap, insert slot and flush counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op <= 3'd0; r_addr <= '0; r_key <= '0;
            r_occ <= '0; r_ins_addr <= '0; r_flush_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin r_op <= cmd_op; r_addr <= cmd_addr; r_key <= cmd_key; end
                end
                S_ISSUE: begin
                    if (!w_err && (r_op == OP_WRITE))  r_occ[r_addr] <= 1'b1;
                    if (!w_err && (r_op == OP_DELETE)) r_occ[r_addr] <= 1'b0;
                    if (!w_err && (r_op == OP_INSERT)) r_ins_addr <= w_free_addr;
                end
                S_INS_WR: r_occ[r_ins_addr] <= 1'b1;
                S_FLUSH: begin
                    if (w_flush_done) begin r_flush_cnt <= '0; r_occ <= '0; end
                    else              r_flush_cnt <= r_flush_cnt + 1'b1;
                end
                default: r_flush_cnt <= r_flush_cnt;
            endcase
        end
    end

`ifdef CAM_DRIVER_STATS_EN
    logic [31:0] r_stat_hit, r_stat_miss;
    logic        w_stat_ev;

    assign w_stat_ev = r_rsp_valid && rsp_ready && !r_rsp_err &&
                       ((r_op == OP_SEARCH) || (r_op == OP_INSERT));
    assign stat_hit  = r_stat_hit;
    assign stat_miss = r_stat_miss;

    // Saturating hit/miss counters for SEARCH and INSERT results
    always_ff @(posedge clk) begin
        if (rst || w_flush_done) begin
            r_stat_hit <= 32'd0; r_stat_miss <= 32'd0;
        end else if (w_stat_ev && r_rsp_hit) begin
            if (r_stat_hit != 32'hFFFF_FFFF) r_stat_hit <= r_stat_hit + 32'd1;
        end else if (w_stat_ev) begin
            if (r_stat_miss != 32'hFFFF_FFFF) r_stat_miss <= r_stat_miss + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_cam_driver.sv
// Directed testbench for cam_driver with a behavioural CAM model attached.
module tb_cam_driver;
    import cam_driver_pkg::*;

    logic        clk = 1'b0, rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, rsp_ready = 1'b0;
    logic [2:0]  cmd_op = 3'd0;
    logic [3:0]  cmd_addr = 4'd0;
    logic [31:0] cmd_key = 32'd0;
    logic        rsp_valid, rsp_hit, rsp_full, rsp_err;
    logic [3:0]  rsp_addr;
    logic [31:0] rsp_key;
    cam_req_t    cam_req;
    cam_resp_t   cam_resp;

    int checks = 0, errors = 0;
    int we_cnt = 0, req_nz = 0;
    logic [3:0] we_addr_q[$];
    logic        res_hit, res_full, res_err;
    logic [3:0]  res_addr;
    logic [31:0] res_key;
    int          res_lat;
    int          n_valid;

    logic [31:0] m_key [16];
    logic [15:0] m_vld;

    always #5 clk = ~clk;

    cam_driver dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_key(cmd_key),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
        .rsp_addr(rsp_addr), .rsp_key(rsp_key), .rsp_full(rsp_full), .rsp_err(rsp_err),
        .cam_req(cam_req), .cam_resp(cam_resp)
    );

    // Behavioural CAM: writes commit at the clock edge, read/search answer combinationally
    always @(posedge clk) begin
        if (rst) m_vld <= 16'd0;
        else if (cam_req.we && cam_req.addr_vld) begin
            m_key[cam_req.addr] <= cam_req.data;
            m_vld[cam_req.addr] <= cam_req.data_vld;
        end
    end

    always_comb begin
        cam_resp = '0;
        if (cam_req.addr_vld && !cam_req.we) begin
            cam_resp.data     = m_key[cam_req.addr];
            cam_resp.data_vld = m_vld[cam_req.addr];
            cam_resp.addr     = cam_req.addr;
            cam_resp.addr_vld = 1'b1;
        end else if (!cam_req.addr_vld && !cam_req.we) begin
            for (int i = 15; i >= 0; i--) begin
                if (m_vld[i] && (m_key[i] == cam_req.data)) begin
                    cam_resp.addr     = 4'(i);
                    cam_resp.addr_vld = 1'b1;
                end
            end
        end
    end

    // Request monitor
    always @(negedge clk) begin
        if (cam_req.we) begin
            we_cnt = we_cnt + 1;
            we_addr_q.push_back(cam_req.addr);
        end
        if (cam_req != '0) req_nz = req_nz + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [3:0] addr, input logic [31:0] key,
                          input int hold);
        int n;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_key = key;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        check("rsp_valid_seen", {63'd0, rsp_valid}, 64'd1);
        res_lat = n; res_hit = rsp_hit; res_addr = rsp_addr; res_key = rsp_key;
        res_full = rsp_full; res_err = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("bp_valid", {63'd0, rsp_valid}, 64'd1);
            check("bp_ready", {63'd0, cmd_ready}, 64'd0);
            check("bp_fields", {31'd0, rsp_hit, rsp_addr, rsp_key, rsp_full, rsp_err, 10'd0},
                  {31'd0, res_hit, res_addr, res_key, res_full, res_err, 10'd0});
        end
        @(negedge clk); rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    initial begin
        int we0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        check("rst_rsp", {59'd0, rsp_valid, rsp_hit, rsp_full, rsp_err, |rsp_addr}, 64'd0);
        check("rst_cam_req", 64'(cam_req), 64'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("idle_cmd_ready", {63'd0, cmd_ready}, 64'd1);

        // WRITE / READ
        do_cmd(3'd1, 4'd3, 32'hDEAD_BEEF, 0);
        check("wr_lat", 64'(res_lat), 64'd1);
        check("wr_hit", {63'd0, res_hit}, 64'd0);
        check("wr_addr", 64'(res_addr), 64'd3);
        do_cmd(3'd0, 4'd3, 32'd0, 0);
        check("rd_key", 64'(res_key), 64'hDEAD_BEEF);
        check("rd_hit", {63'd0, res_hit}, 64'd1);
        check("rd_lat", 64'(res_lat), 64'd1);

        // SEARCH hit / miss
        do_cmd(3'd3, 4'd0, 32'hDEAD_BEEF, 0);
        check("srch_hit", {63'd0, res_hit}, 64'd1);
        check("srch_addr", 64'(res_addr), 64'd3);
        do_cmd(3'd3, 4'd0, 32'h0000_1234, 0);
        check("srch_miss", {63'd0, res_hit}, 64'd0);

        // DELETE empties the CAM again, then INSERT allocation
        do_cmd(3'd2, 4'd3, 32'd0, 0);
        check("del_prior", {63'd0, res_hit}, 64'd1);
        for (int i = 0; i < 16; i++) begin
            do_cmd(3'd4, 4'd0, 32'(i + 1), 0);
            check("ins_addr", 64'(res_addr), 64'(i));
            check("ins_hit_lat", {62'd0, res_hit, res_full, 32'(res_lat)}, {64'd2});
        end
        do_cmd(3'd4, 4'd0, 32'd5, 0);
        check("ins_dup", {59'd0, res_hit, res_addr}, {59'd0, 1'b1, 4'd4});
        check("ins_dup_lat", 64'(res_lat), 64'd1);
        we0 = we_cnt;
        do_cmd(3'd4, 4'd0, 32'd17, 0);
        check("ins_full", {62'd0, res_full, res_hit}, 64'd2);
        check("ins_full_no_we", 64'(we_cnt), 64'(we0));

        // DELETE then INSERT reuses the hole
        do_cmd(3'd2, 4'd5, 32'd0, 0);
        check("del5_prior", {63'd0, res_hit}, 64'd1);
        do_cmd(3'd4, 4'd0, 32'h0000_AAAA, 0);
        check("reins_addr", 64'(res_addr), 64'd5);
        check("reins_hit", {63'd0, res_hit}, 64'd0);
        do_cmd(3'd3, 4'd0, 32'd6, 0);
        check("deleted_miss", {63'd0, res_hit}, 64'd0);

        // Backpressure: fields held for 5 cycles
        do_cmd(3'd3, 4'd0, 32'h0000_AAAA, 5);
        check("bp_hit_addr", {59'd0, res_hit, res_addr}, {59'd0, 1'b1, 4'd5});

        // FLUSH
        we_addr_q.delete();
        we0 = we_cnt;
        do_cmd(3'd5, 4'd0, 32'd0, 0);
        check("flush_lat", 64'(res_lat), 64'd17);
        check("flush_we_cnt", 64'(we_cnt - we0), 64'd16);
        for (int i = 0; i < 16; i++) begin
            if (i < we_addr_q.size()) check("flush_we_addr", 64'(we_addr_q[i]), 64'(i));
        end
        check("flush_rsp_addr", 64'(res_addr), 64'd15);
        do_cmd(3'd3, 4'd0, 32'd1, 0);
        check("post_flush_miss1", {63'd0, res_hit}, 64'd0);
        do_cmd(3'd3, 4'd0, 32'h0000_AAAA, 0);
        check("post_flush_miss2", {63'd0, res_hit}, 64'd0);

        // Reset during FLUSH drops the command and clears occupancy
        do_cmd(3'd4, 4'd0, 32'h77, 0);
        check("pre_rst_ins", 64'(res_addr), 64'd0);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd5; cmd_addr = 4'd0; cmd_key = 32'd0;
        @(posedge clk); #1 cmd_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_ready", {63'd0, cmd_ready}, 64'd0);
        @(negedge clk); rst = 1'b0;
        n_valid = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (rsp_valid) n_valid++;
        end
        check("mid_rst_no_rsp", 64'(n_valid), 64'd0);
        check("mid_rst_idle", {63'd0, cmd_ready}, 64'd1);
        do_cmd(3'd4, 4'd0, 32'h88, 0);
        check("occ_cleared", {59'd0, res_hit, res_addr}, 64'd0);

        // Reserved ops
        we0 = we_cnt; req_nz = 0;
        do_cmd(3'd7, 4'd2, 32'h1234_5678, 0);
        check("err7", {62'd0, res_err, res_hit}, 64'd2);
        check("err7_fields", {27'd0, res_full, res_addr, res_key}, 64'd0);
        check("err7_lat", 64'(res_lat), 64'd1);
        check("err7_req", 64'(req_nz), 64'd0);
        check("err7_we", 64'(we_cnt), 64'(we0));
        do_cmd(3'd6, 4'd0, 32'd0, 0);
        check("err6", {63'd0, res_err}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
